ocd_adc_reader: RTL and testbench

Serial front end for the overcurrent-detect ADC, a 10-bit SPI-style converter such as the ADC101S051. It clocks conversion frames out of the converter continuously while enabled and presents each result on a held 10-bit `adc_dout` bus with a one-cycle `adc_valid` strobe. `qcw_ocd_control` consumes `adc_dout` directly as its overcurrent sample input.

---
 rtl/ocd_pkg.sv | 15 +
 rtl/ocd_adc_reader_if.sv | 20 ++
 rtl/ocd_adc_reader_sync2.sv | 21 ++
 rtl/ocd_adc_reader.sv | 143 ++++++++++++++
 tb/tb_ocd_adc_reader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ocd_pkg.sv
// Shared types and frame-layout constants for the overcurrent-detect ADC reader.
package ocd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        QUIET,
        CONV,
        DONE
    } adc_state_e;

    localparam int unsigned ADC_FRAME_BITS = 16;
    localparam int unsigned ADC_LEAD_BITS  = 3;
    localparam int unsigned ADC_DATA_BITS  = 10;

endpackage

// File: rtl/ocd_adc_reader_if.sv
// Serial converter pins: chip select, serial clock and serial data.
interface ocd_adc_reader_if;

    logic adc_cs_n;
    logic adc_sclk;
    logic adc_sdata;

    modport master (
        output adc_cs_n,
        output adc_sclk,
        input  adc_sdata
    );

    modport slave (
        input  adc_cs_n,
        input  adc_sclk,
        output adc_sdata
    );

endinterface

// File: rtl/ocd_adc_reader_sync2.sv
// Two-flop synchronizer for the asynchronous converter data line.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ocd_adc_reader.sv
// Continuous 16-clock frame reader for a 10-bit serial ADC; publishes each clean
// result on a held bus with a one-cycle strobe and flags corrupted leading zeros.
module ocd_adc_reader
    import ocd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_HIGH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    ocd_adc_reader_if.master         adc_bus,
    output logic [ADC_DATA_BITS-1:0] adc_dout,
    output logic                     adc_valid,
    output logic                     adc_frame_err
);

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(CS_HIGH - 1);
    localparam logic [3:0] BIT_LAST   = 4'(ADC_FRAME_BITS - 1);

    adc_state_e state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [7:0] quiet_q, quiet_d;
    logic [3:0] bit_q, bit_d;
    logic       cs_n_q, cs_n_d;
    logic       sclk_q, sclk_d;
    logic [ADC_DATA_BITS-1:0] dout_d;
    logic       valid_d;
    logic       err_d;
    logic       sdata_sync;

    // Only the first 15 captured bits are stored; the last bit is decoded straight
    // from the synchronizer so the result can register into the DONE cycle.
    logic [ADC_FRAME_BITS-2:0] shift_q, shift_d;
    logic [ADC_FRAME_BITS-1:0] frame_w;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (adc_bus.adc_sdata),
        .q   (sdata_sync)
    );

    assign frame_w          = {shift_q, sdata_sync};
    assign adc_bus.adc_cs_n = cs_n_q;
    assign adc_bus.adc_sclk = sclk_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        quiet_d = quiet_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b1;
        dout_d  = adc_dout;
        valid_d = 1'b0;
        err_d   = adc_frame_err;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = QUIET;
                    quiet_d = '0;
                end
            end
            QUIET: begin
                if (quiet_q == QUIET_LAST) begin
                    state_d = CONV;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    quiet_d = quiet_q + 8'd1;
                end
            end
            CONV: begin
                cs_n_d = 1'b0;
                sclk_d = sclk_q;
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else begin
                        shift_d = frame_w[ADC_FRAME_BITS-2:0];
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                            cs_n_d  = 1'b1;
                            sclk_d  = 1'b1;
                            if (frame_w[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS] == '0) begin
                                dout_d  = frame_w[ADC_FRAME_BITS-ADC_LEAD_BITS-1 -: ADC_DATA_BITS];
                                valid_d = 1'b1;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else begin
                            bit_d  = bit_q + 4'd1;
                            sclk_d = 1'b0;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            DONE: begin
                quiet_d = '0;
                state_d = enable ? QUIET : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            div_q         <= '0;
            quiet_q       <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b1;
            adc_dout      <= '0;
            adc_valid     <= 1'b0;
            adc_frame_err <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            quiet_q       <= quiet_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            cs_n_q        <= cs_n_d;
            sclk_q        <= sclk_d;
            adc_dout      <= dout_d;
            adc_valid     <= valid_d;
            adc_frame_err <= err_d;
        end
    end

endmodule

// File: tb/tb_ocd_adc_reader.sv
// Bench for ocd_adc_reader: default-parameter and fastest-parameter instances
// driven by a behavioural converter model with randomized data-out delay.
module tb_ocd_adc_reader;

    typedef struct {
        logic [15:0] word;
        logic        exp_valid;
        logic [9:0]  exp_dout;
        logic        exp_err;
    } vec_t;

    logic       clk;
    logic       rst0, rst1, en0, en1;
    logic [9:0] dout0, dout1;
    logic       valid0, valid1, err0, err1;

    int n_vec = 0;
    int n_bad = 0;

    ocd_adc_reader_if bus0 ();
    ocd_adc_reader_if bus1 ();

    ocd_adc_reader u_dut0 (
        .clk           (clk),
        .rst           (rst0),
        .enable        (en0),
        .adc_bus       (bus0),
        .adc_dout      (dout0),
        .adc_valid     (valid0),
        .adc_frame_err (err0)
    );

    ocd_adc_reader #(.CLK_DIV(3), .CS_HIGH(1)) u_dut1 (
        .clk           (clk),
        .rst           (rst1),
        .enable        (en1),
        .adc_bus       (bus1),
        .adc_dout      (dout1),
        .adc_valid     (valid1),
        .adc_frame_err (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic get_cs(input int d);
        return (d == 0) ? bus0.adc_cs_n : bus1.adc_cs_n;
    endfunction
    function automatic logic get_sclk(input int d);
        return (d == 0) ? bus0.adc_sclk : bus1.adc_sclk;
    endfunction
    function automatic logic get_valid(input int d);
        return (d == 0) ? valid0 : valid1;
    endfunction
    function automatic logic [9:0] get_dout(input int d);
        return (d == 0) ? dout0 : dout1;
    endfunction
    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err1;
    endfunction

    // Converter model: each SCLK fall under CS_n shifts out the next frame bit, MSB first.
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic        sd[2]        = '{1'b0, 1'b0};
    logic        prev_sclk[2] = '{1'b1, 1'b1};
    logic        pend[2]      = '{1'b0, 1'b0};
    logic        pend_v[2]    = '{1'b0, 1'b0};
    int          fall_idx[2]  = '{0, 0};
    logic [15:0] cur_w[2]     = '{16'h0, 16'h0};

    assign bus0.adc_sdata = sd[0];
    assign bus1.adc_sdata = sd[1];

    function automatic logic [15:0] pop_word(input int d);
        if (d == 0) return (q0.size() > 0) ? q0.pop_front() : 16'h0;
        return (q1.size() > 0) ? q1.pop_front() : 16'h0;
    endfunction

    always begin
        logic cs, sc, v;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            cs = get_cs(d);
            sc = get_sclk(d);
            if (pend[d]) begin
                sd[d]   = pend_v[d];
                pend[d] = 1'b0;
            end
            if (prev_sclk[d] && !sc && !cs && fall_idx[d] < 16) begin
                if (fall_idx[d] == 0) cur_w[d] = pop_word(d);
                v = cur_w[d][15 - fall_idx[d]];
                fall_idx[d]++;
                if ($urandom_range(0, 1) == 1) begin
                    pend[d]   = 1'b1;
                    pend_v[d] = v;
                end else begin
                    sd[d] = v;
                end
            end
            if (cs) fall_idx[d] = 0;
            prev_sclk[d] = sc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Follows one frame to its DONE cycle, measuring SCLK half-period runs under CS_n.
    task automatic wait_done(input int d, input int half, output int cyc, output int pulses,
                             output int runs, output int bad, output logic at_valid,
                             output logic [9:0] at_dout, output logic at_err);
        logic pcs, psc, ccs, csc;
        int   run;
        pcs = get_cs(d);
        psc = get_sclk(d);
        run = 0; pulses = 0; runs = 0; bad = 0; cyc = 0;
        at_valid = 1'b0; at_dout = '0; at_err = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            ccs = get_cs(d);
            csc = get_sclk(d);
            if (get_valid(d)) pulses++;
            if (!ccs) begin
                if (!pcs && csc == psc) run++;
                else begin
                    if (!pcs) begin
                        runs++;
                        if (run != half) bad++;
                    end
                    run = 1;
                end
            end else if (!pcs) begin
                runs++;
                if (run != half) bad++;
                cyc      = c;
                at_valid = get_valid(d);
                at_dout  = get_dout(d);
                at_err   = get_err(d);
                return;
            end
            pcs = ccs;
            psc = csc;
        end
        n_vec++;
        n_bad++;
        $display("FAIL frame_timeout dut%0d: got no frame end, required one within 1000 cycles", d);
    endtask

    task automatic wait_fall(input int d, input int idx);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (fall_idx[d] >= idx) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL fall_timeout dut%0d: got fewer than %0d SCLK falls", d, idx);
    endtask

    task automatic cs_fall_delay(input int d, output int k);
        k = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (!get_cs(d)) begin
                k = c;
                return;
            end
        end
    endtask

    task automatic run_table(input int d, input int half, input int period, input int count,
                             input logic [15:0] tail_word, ref vec_t vecs[$]);
        int cyc, pulses, runs, bad;
        logic av, ae;
        logic [9:0] ad;
        for (int i = 0; i < count; i++) begin
            wait_done(d, half, cyc, pulses, runs, bad, av, ad, ae);
            check($sformatf("valid_at_done d%0d v%0d", d, i), 32'(av), 32'(vecs[i].exp_valid));
            check($sformatf("dout d%0d v%0d", d, i), 32'(ad), 32'(vecs[i].exp_dout));
            check($sformatf("frame_err d%0d v%0d", d, i), 32'(ae), 32'(vecs[i].exp_err));
            check($sformatf("valid_pulses d%0d v%0d", d, i), 32'(pulses), 32'(vecs[i].exp_valid));
            if (i > 0) begin
                check($sformatf("period d%0d v%0d", d, i), 32'(cyc), 32'(period));
                check($sformatf("half_periods d%0d v%0d", d, i), 32'(runs), 32'd32);
                check($sformatf("bad_half_period d%0d v%0d", d, i), 32'(bad), 32'd0);
            end
            if (d == 0) q0.push_back((i + 1 < count) ? vecs[i + 1].word : tail_word);
            else        q1.push_back((i + 1 < count) ? vecs[i + 1].word : tail_word);
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [15:0] w;
        logic [9:0]  m_dout;
        logic        m_err, m_valid, av, ae;
        logic [9:0]  ad;
        int          k, cyc, pulses, runs, bad, lows;

        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset cs_n", 32'(bus0.adc_cs_n), 32'd1);
        check("reset sclk", 32'(bus0.adc_sclk), 32'd1);
        check("reset dout", 32'(dout0), 32'd0);
        check("reset valid", 32'(valid0), 32'd0);
        check("reset frame_err", 32'(err0), 32'd0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        vecs.push_back('{16'h1668, 1'b1, 10'h2CD, 1'b0});
        vecs.push_back('{16'h1FF8, 1'b1, 10'h3FF, 1'b0});
        vecs.push_back('{16'h0007, 1'b1, 10'h000, 1'b0});
        vecs.push_back('{16'h1000, 1'b1, 10'h200, 1'b0});
        vecs.push_back('{16'h82A8, 1'b0, 10'h200, 1'b1});
        vecs.push_back('{16'h2555, 1'b0, 10'h200, 1'b1});
        vecs.push_back('{16'h0AA8, 1'b1, 10'h155, 1'b1});
        m_dout = 10'h155;
        m_err  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) != 0) w = w % 16'h2000;
            if (w / 16'h2000 == 0) begin
                m_dout  = 10'((w / 8) % 1024);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_err   = 1'b1;
            end
            vecs.push_back('{w, m_valid, m_dout, m_err});
        end

        // Continuous conversions on the default instance.
        q0.push_back(vecs[0].word);
        en0 = 1'b1;
        cs_fall_delay(0, k);
        check("cs_fall_delay d0", 32'(k), 32'd5);
        run_table(0, 4, 133, vecs.size(), 16'h0780, vecs);

        // Enable dropped mid-frame: the frame finishes and nothing follows.
        wait_fall(0, 7);
        en0 = 1'b0;
        wait_done(0, 4, cyc, pulses, runs, bad, av, ad, ae);
        check("drop_en valid", 32'(av), 32'd1);
        check("drop_en dout", 32'(ad), 32'h0F0);
        check("drop_en pulses", 32'(pulses), 32'd1);
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (!bus0.adc_cs_n || !bus0.adc_sclk || valid0) lows++;
        end
        check("drop_en idle", 32'(lows), 32'd0);

        // Reset in the middle of a frame.
        q0.push_back(16'h1FF8);
        en0 = 1'b1;
        wait_fall(0, 10);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        check("midrst cs_n", 32'(bus0.adc_cs_n), 32'd1);
        check("midrst sclk", 32'(bus0.adc_sclk), 32'd1);
        check("midrst dout", 32'(dout0), 32'd0);
        check("midrst valid", 32'(valid0), 32'd0);
        check("midrst frame_err", 32'(err0), 32'd0);
        @(negedge clk);
        q0.push_back(16'h1668);
        rst0 = 1'b0;
        wait_done(0, 4, cyc, pulses, runs, bad, av, ad, ae);
        check("postrst valid", 32'(av), 32'd1);
        check("postrst dout", 32'(ad), 32'h2CD);
        check("postrst pulses", 32'(pulses), 32'd1);
        check("postrst half_periods", 32'(runs), 32'd32);
        check("postrst bad_half_period", 32'(bad), 32'd0);
        check("postrst frame_err", 32'(ae), 32'd0);
        en0 = 1'b0;

        // Fastest legal timing on the second instance.
        q1.push_back(vecs[0].word);
        en1 = 1'b1;
        cs_fall_delay(1, k);
        check("cs_fall_delay d1", 32'(k), 32'd2);
        run_table(1, 3, 98, 10, 16'h0000, vecs);
        en1 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
